packet_output_scheduler: RTL and testbench
==========================================

Name: packet_output_scheduler

Overview:
- Clocked, packet-aware controller for one router output channel.
- Shares the channel among N input ports, each using a 4-phase req/ack handshake.
- Picks a winner by round-robin and forwards its handshake to the downstream channel.
- Holds the grant across all flits of a packet until the tail-flit handshake completes, so flits of different packets never interleave on one output.

Parameters:
N, 5, number of requesting input ports (N, E, S, W, Local).
SEL_W, 3, width of selected; must satisfy 2^SEL_W > N (all-ones is the "none" code).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
reqs_in  input  N  per-port 4-phase request (level).
tails_in  input  N  per-port tail-flit flag; valid whenever the matching reqs_in bit is high.
acks_in  output  N  per-port 4-phase acknowledge, one-hot or zero.
req_out  output  1  request to downstream channel.
ack_out  input  1  acknowledge from downstream channel.
selected  output  SEL_W  index of the granted port; all-ones when idle.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (reset=0), applied immediately and asynchronously:
  - req_out=0, acks_in=0, busy=0, selected=all-ones.
  - state=IDLE, ptr=N-1, tail_r=0.
  - Reset mid-handshake abandons the transfer.
- Round-robin search order is ptr+1, ptr+2, …, ptr+N (mod N); the first requester found wins.
  - ptr updates to the winner only on packet release (tail complete).
- States:
  - IDLE:
    - If any reqs_in bit is high, latch winner w into selected and tail_r<=tails_in[w].
    - Set req_out<=1 and go to FWD.
    - req_out is therefore high exactly 1 cycle after the request is sampled.
  - FWD: wait ack_out=1, then acks_in[sel]<=1 and go to REL.
  - REL: wait reqs_in[sel]=0, then req_out<=0 and go to DONE.
  - DONE: wait ack_out=0, then acks_in[sel]<=0.
    - If tail_r=1: ptr<=sel, selected<=all-ones, go to IDLE.
    - Else go to HOLD.
  - HOLD:
    - Wait reqs_in[sel]=1, then tail_r<=tails_in[sel], req_out<=1, go to FWD.
    - Requests from other ports are ignored; selected stays at the granted index.
- Only acks_in[selected] may ever be high; all other bits stay 0.
- A request from another port arriving in any non-IDLE state waits; it is not lost, because request levels are held by the sender.
- A port dropping its request before ack is a protocol violation; behaviour is undefined and not checked.
- When IDLE is re-entered and requests are pending, arbitration happens in the same cycle as entry evaluation, i.e. the first IDLE cycle.
- Single-flit packet (tail=1 on first flit) releases the lock after one full 4-phase cycle.
- N=1 degenerates to a pass-through with the same latency.

Test Plan:
- Reset check: hold reset=0 with reqs_in=5'b11111.
  - Required: req_out=0, acks_in=0, selected=7, busy=0.
  - Assert reset=0 mid-FWD: outputs return to these values without waiting for a clk edge.
- Two requesters: after reset, reqs_in[1]=reqs_in[2]=1, tails=1; downstream acks 1 cycle after req_out.
  - Required: port 1 granted first (selected=1, acks_in=5'b00010).
  - After its handshake completes and selected=7 for the release cycle, port 2 is granted (selected=2).
- Packet lock: port 3 sends 3 flits with tails 0,0,1 while reqs_in[0]=1 throughout.
  - Required: selected=3 and acks_in[0]=0 for all three flits.
  - After the third flit's DONE, port 0 is granted and ptr=3.
- Fairness: all 5 ports request single-flit packets continuously.
  - Required: grant order 0,1,2,3,4,0,1, and no port is granted twice before the others.
- Timing: in IDLE, raise reqs_in[4] before edge k.
  - Required: req_out=1 and selected=4 after edge k.
  - With ack_out rising before edge k+2, acks_in[4]=1 after edge k+2.
- Reset abort: reset pulses low while port 2 is in HOLD between flits.
  - Required: after release, port 0 (not 2) wins if both 0 and 2 request, because ptr is back at N-1.

Source files
------------

// File: rtl/packet_output_scheduler.sv
// packet_output_scheduler: round-robin, packet-locked arbiter for one router
// output channel. Input ports use 4-phase req/ack; the winner's handshake is
// forwarded downstream and the grant is held until its tail flit completes.
module packet_output_scheduler #(
  parameter int N     = 5,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     reqs_in,
  input  logic [N-1:0]     tails_in,
  output logic [N-1:0]     acks_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [SEL_W-1:0] selected,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_NONE = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FWD  = 3'd1,
    S_REL  = 3'd2,
    S_DONE = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  state_e           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic             tail_q;
  logic             req_q;
  logic [N-1:0]     acks_q;
  logic             busy_q;

  logic             win_valid_s;
  logic [SEL_W-1:0] win_idx_s;
  logic             win_tail_s;
  logic             sel_req_s;
  logic             sel_tail_s;

  // Bit of a port vector addressed by an encoded index (0 for out-of-range codes).
  function automatic logic bit_at(input logic [N-1:0] vec, input logic [SEL_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int j = 0; j < N; j++) begin
      b = (SEL_W'(j) == idx) ? vec[j] : b;
    end
    return b;
  endfunction

  // One-hot port vector for an encoded index (all zero for out-of-range codes).
  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      v[j] = (SEL_W'(j) == idx);
    end
    return v;
  endfunction

  // Round-robin search from ptr+1 upwards; scanning backwards lets the
  // nearest requester overwrite any farther one.
  always_comb begin
    logic [SEL_W-1:0] cand;
    logic             hit;
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    for (int k = N; k >= 1; k--) begin
      cand        = SEL_W'((int'(ptr_q) + k) % N);
      hit         = bit_at(reqs_in, cand);
      win_idx_s   = hit ? cand : win_idx_s;
      win_valid_s = win_valid_s | hit;
    end
  end

  assign win_tail_s = bit_at(tails_in, win_idx_s);
  assign sel_req_s  = bit_at(reqs_in, sel_q);
  assign sel_tail_s = bit_at(tails_in, sel_q);

  // Handshake sequencer: arbitration, packet lock and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_INIT;
      sel_q   <= SEL_NONE;
      tail_q  <= 1'b0;
      req_q   <= 1'b0;
      acks_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_valid_s) begin
            sel_q   <= win_idx_s;
            tail_q  <= win_tail_s;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_FWD;
          end
        end
        S_FWD: begin
          if (ack_out) begin
            acks_q  <= onehot(sel_q);
            state_q <= S_REL;
          end
        end
        S_REL: begin
          if (!sel_req_s) begin
            req_q   <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!ack_out) begin
            acks_q <= '0;
            if (tail_q) begin
              // Packet finished: release the channel and rotate priority.
              ptr_q   <= sel_q;
              sel_q   <= SEL_NONE;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Only the locked port may continue; other requesters keep waiting.
          if (sel_req_s) begin
            tail_q  <= sel_tail_s;
            req_q   <= 1'b1;
            state_q <= S_FWD;
          end
        end
        default: begin
          state_q <= S_IDLE;
          sel_q   <= SEL_NONE;
          tail_q  <= 1'b0;
          req_q   <= 1'b0;
          acks_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign acks_in  = acks_q;
  assign req_out  = req_q;
  assign selected = sel_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_packet_output_scheduler.sv
// Self-checking bench for packet_output_scheduler. The bench plays all input
// ports and the downstream channel; a packet-level model (pending flit counts,
// priority pointer, lock owner) predicts every grant.
module tb_packet_output_scheduler;

  localparam int N     = 5;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] NONE = 3'b111;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     reqs_in  = '0;
  logic [N-1:0]     tails_in = '0;
  logic [N-1:0]     acks_in;
  logic             req_out;
  logic             ack_out = 1'b0;
  logic [SEL_W-1:0] selected;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: flits still to send per port, last winner, lock owner.
  int flits_left[N];
  int ptr_m  = N - 1;
  int lock_m = -1;
  int grants[$];
  int exp_fair[7] = '{0, 1, 2, 3, 4, 0, 1};

  packet_output_scheduler #(.N(N), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqs_in  (reqs_in),
    .tails_in (tails_in),
    .acks_in  (acks_in),
    .req_out  (req_out),
    .ack_out  (ack_out),
    .selected (selected),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot_of(input int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // First port with pending flits, scanning after the last winner.
  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (ptr_m + k) % N;
      if (flits_left[p] > 0) return p;
    end
    return -1;
  endfunction

  // Senders hold request high while they have flits; gap_port stays low.
  task automatic drive_reqs(input int gap_port);
    for (int p = 0; p < N; p++) begin
      reqs_in[p]  = (flits_left[p] > 0) && (p != gap_port);
      tails_in[p] = (flits_left[p] == 1);
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) flits_left[p] = 0;
    reqs_in  = '0;
    tails_in = '0;
  endtask

  // Asynchronous reset pulse taken between clock edges.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_req", req_out, 32'd0);
    chk("rst_acks", acks_in, 32'd0);
    chk("rst_sel", selected, 32'd7);
    chk("rst_busy", busy, 32'd0);
    ack_out = 1'b0;
    tick();
    reset  = 1'b1;
    ptr_m  = N - 1;
    lock_m = -1;
  endtask

  // One complete flit handshake through the scheduler, checked cycle by cycle.
  task automatic flit_cycle();
    int   w;
    logic exp_tail;
    w = (lock_m >= 0) ? lock_m : rr_pick();
    if (w < 0) begin
      flits_left[$urandom_range(N - 1, 0)] = 1;
      w = rr_pick();
    end
    if (lock_m >= 0) begin
      int gap;
      gap = $urandom_range(2, 0);
      drive_reqs(lock_m);
      for (int i = 0; i < gap; i++) begin
        tick();
        chk("hold_sel", selected, w);
        chk("hold_req", req_out, 32'd0);
        chk("hold_acks", acks_in, 32'd0);
      end
    end
    drive_reqs(-1);
    exp_tail = (flits_left[w] == 1);
    tick();
    chk("req_rise", req_out, 32'd1);
    chk("grant", selected, w);
    chk("busy_fwd", busy, 32'd1);
    chk("acks_fwd", acks_in, 32'd0);
    grants.push_back(int'(selected));
    ack_out = 1'b1;
    tick();
    chk("ack_rise", acks_in, onehot_of(w));
    chk("req_held", req_out, 32'd1);
    reqs_in[w] = 1'b0;
    tick();
    chk("req_fall", req_out, 32'd0);
    chk("ack_held", acks_in, onehot_of(w));
    ack_out = 1'b0;
    tick();
    chk("ack_fall", acks_in, 32'd0);
    flits_left[w]--;
    if (exp_tail) begin
      ptr_m  = w;
      lock_m = -1;
      chk("rel_sel", selected, 32'd7);
      chk("rel_busy", busy, 32'd0);
    end else begin
      lock_m = w;
      chk("hold_sel0", selected, w);
      chk("hold_busy", busy, 32'd1);
    end
  endtask

  initial begin
    for (int p = 0; p < N; p++) flits_left[p] = 0;

    // Reset state with every port requesting.
    reqs_in  = '1;
    tails_in = '1;
    #1 reset = 1'b0;
    #1;
    chk("rst0_req", req_out, 32'd0);
    chk("rst0_acks", acks_in, 32'd0);
    chk("rst0_sel", selected, 32'd7);
    chk("rst0_busy", busy, 32'd0);
    tick();
    tick();
    chk("rst1_req", req_out, 32'd0);
    chk("rst1_sel", selected, 32'd7);
    reset = 1'b1;
    clear_all();

    // Two single-flit requesters: port 1 first, then port 2.
    grants.delete();
    flits_left[1] = 1;
    flits_left[2] = 1;
    flit_cycle();
    flit_cycle();
    chk("two_first", grants[0], 32'd1);
    chk("two_second", grants[1], 32'd2);

    // Packet lock: port 3 sends three flits while port 0 waits.
    grants.delete();
    flits_left[3] = 3;
    flits_left[0] = 1;
    for (int i = 0; i < 4; i++) flit_cycle();
    chk("lock_f0", grants[0], 32'd3);
    chk("lock_f1", grants[1], 32'd3);
    chk("lock_f2", grants[2], 32'd3);
    chk("lock_next", grants[3], 32'd0);

    // Fairness: all ports request single-flit packets continuously.
    pulse_reset();
    clear_all();
    for (int p = 0; p < N; p++) flits_left[p] = 1;
    grants.delete();
    for (int i = 0; i < 7; i++) begin
      flit_cycle();
      flits_left[grants[i]] = 1;
    end
    clear_all();
    for (int i = 0; i < 7; i++) chk("fair_order", grants[i], exp_fair[i]);

    // Timing: request before edge k, req_out after k, ack one cycle later.
    reqs_in  = 5'b10000;
    tails_in = 5'b10000;
    tick();
    chk("tim_req", req_out, 32'd1);
    chk("tim_sel", selected, 32'd4);
    tick();
    chk("tim_noack", acks_in, 32'd0);
    ack_out = 1'b1;
    tick();
    chk("tim_ack", acks_in, 32'h10);
    reqs_in = '0;
    tick();
    ack_out = 1'b0;
    tick();
    chk("tim_rel", selected, 32'd7);
    ptr_m = 4;

    // Reset asserted mid-FWD abandons the transfer at once.
    reqs_in  = 5'b00100;
    tails_in = 5'b00000;
    tick();
    chk("abort_fwd", req_out, 32'd1);
    pulse_reset();
    clear_all();

    // Reset while port 2 sits in HOLD: priority pointer returns to N-1.
    flits_left[2] = 2;
    flit_cycle();
    chk("abort_hold", busy, 32'd1);
    pulse_reset();
    clear_all();
    flits_left[0] = 1;
    flits_left[2] = 1;
    grants.delete();
    flit_cycle();
    flit_cycle();
    chk("abort_win0", grants[0], 32'd0);
    chk("abort_win2", grants[1], 32'd2);

    // Randomized packet traffic checked against the model.
    for (int it = 0; it < 150; it++) begin
      for (int p = 0; p < N; p++) begin
        if (flits_left[p] == 0 && $urandom_range(3, 0) == 0)
          flits_left[p] = $urandom_range(3, 1);
      end
      flit_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
